// File: rtl/fp32_pkg.sv
// ============================================================================
// Module : fp32_pkg
// Brief  : Shared FP32 types, constants and flag indices for the add/sub
//          post-processing back end.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fp32_pkg;

    localparam int          BIAS    = 127;
    localparam logic [7:0]  EXP_MAX = 8'hFF;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam int          MANT_W  = 28;

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    // Result class decided in the normalise stage and carried to the pack stage
    typedef enum logic [2:0] {
        K_NORM  = 3'd0,
        K_ZERO  = 3'd1,
        K_UFLOW = 3'd2,
        K_INF   = 3'd3,
        K_NAN   = 3'd4
    } kind_t;

    function automatic fp32_t pack_inf(input logic sign);
        fp32_t r;
        r.sign = sign;
        r.exp  = EXP_MAX;
        r.frac = '0;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lzc27.sv
// ============================================================================
// Module : lzc27
// Brief  : Combinational 27-bit leading-zero counter with all-zero flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lzc27 (
    input  logic [26:0] a,
    output logic [4:0]  cnt,
    output logic        zero
);

    // Scanning upward lets the highest set bit win the final assignment
    always_comb begin
        cnt  = 5'd0;
        zero = 1'b1;
        for (int i = 0; i < 27; i++) begin
            if (a[i]) begin
                cnt  = 5'(26 - i);
                zero = 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp32_addsub_postprocessing.sv
// ============================================================================
// Module : fp32_addsub_postprocessing
// Brief  : FP32 add/sub back end: S1 normalise, S2 round-nearest-even + pack,
//          valid/ready handshake. Optional macro FP32_POST_FLAGS_EN adds
//          out_flags = {invalid, overflow, underflow, inexact}.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fp32_addsub_postprocessing
    import fp32_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_W-1:0]        in_exp,
    input  logic [FRAC_W+4:0]       in_mant,
    input  logic                    in_inf,
    input  logic                    in_nan,
    output logic                    out_valid,
    input  logic                    out_ready,
`ifdef FP32_POST_FLAGS_EN
    output logic [3:0]              out_flags,
`endif
    output logic [EXP_W+FRAC_W:0]   out_result
);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_s1_valid;
    logic r_out_valid;
    logic w_s2_adv;
    logic w_s1_adv;

    assign w_s2_adv  = !r_out_valid || out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign in_ready  = w_s1_adv;
    assign out_valid = r_out_valid;

    // ------------------------------------------------------------------
    // S1: normalise
    // ------------------------------------------------------------------
    logic [4:0]         w_lz;
    logic               w_lz_zero;
    logic [26:0]        w_mant_shl;
    logic signed [9:0]  w_exp_in;
    logic signed [9:0]  w_exp_norm;
    logic [25:0]        w_mant_norm;
    kind_t              w_kind;

    lzc27 u_lzc (
        .a    (in_mant[26:0]),
        .cnt  (w_lz),
        .zero (w_lz_zero)
    );

    assign w_mant_shl = in_mant[26:0] << w_lz;
    assign w_exp_in   = $signed({2'b00, in_exp});

    always_comb begin
        w_kind      = K_NORM;
        w_exp_norm  = w_exp_in;
        w_mant_norm = '0;
        if (in_nan) begin
            w_kind = K_NAN;
        end else if (in_inf) begin
            w_kind = K_INF;
        end else if (in_mant[27]) begin
            // Carry: the bit dropped off the right end folds into sticky
            w_mant_norm = {in_mant[26:2], in_mant[1] | in_mant[0]};
            w_exp_norm  = w_exp_in + 10'sd1;
        end else if (w_lz_zero) begin
            w_kind = K_ZERO;
        end else begin
            w_mant_norm = w_mant_shl[25:0];
            w_exp_norm  = w_exp_in - $signed({5'b00000, w_lz});
            if (w_exp_norm <= 10'sd0) begin
                w_kind = K_UFLOW;
            end
        end
    end

    logic               r_s1_sign;
    logic signed [9:0]  r_s1_exp;
    logic [25:0]        r_s1_mant;
    kind_t              r_s1_kind;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_mant  <= '0;
            r_s1_kind  <= K_ZERO;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign <= in_sign;
                r_s1_exp  <= w_exp_norm;
                r_s1_mant <= w_mant_norm;
                r_s1_kind <= w_kind;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: round to nearest even, pack
    // ------------------------------------------------------------------
    logic               w_round_up;
    logic [23:0]        w_frac_rnd;
    logic signed [9:0]  w_exp_fin;
    logic               w_ovf;
    fp32_t              w_result;

    // mant layout here: [25:3] frac, [2] guard, [1] round, [0] sticky
    assign w_round_up = r_s1_mant[2] & (r_s1_mant[1] | r_s1_mant[0] | r_s1_mant[3]);
    assign w_frac_rnd = {1'b0, r_s1_mant[25:3]} + {23'b0, w_round_up};
    assign w_exp_fin  = r_s1_exp + $signed({9'b0, w_frac_rnd[23]});
    assign w_ovf      = (w_exp_fin >= 10'sd255);

    always_comb begin
        w_result = '0;
        case (r_s1_kind)
            K_NAN:   w_result = QNAN;
            K_INF:   w_result = pack_inf(r_s1_sign);
            K_UFLOW: w_result.sign = r_s1_sign;
            K_NORM: begin
                if (w_ovf) begin
                    w_result = pack_inf(r_s1_sign);
                end else begin
                    w_result.sign = r_s1_sign;
                    w_result.exp  = w_exp_fin[7:0];
                    w_result.frac = w_frac_rnd[22:0];
                end
            end
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            out_result  <= '0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_result <= w_result;
            end
        end
    end

`ifdef FP32_POST_FLAGS_EN
    logic [3:0] w_flags;

    always_comb begin
        w_flags                 = '0;
        w_flags[FLAG_INVALID]   = (r_s1_kind == K_NAN);
        w_flags[FLAG_OVERFLOW]  = (r_s1_kind == K_NORM) && w_ovf;
        w_flags[FLAG_UNDERFLOW] = (r_s1_kind == K_UFLOW);
        w_flags[FLAG_INEXACT]   = ((r_s1_kind == K_NORM) && ((|r_s1_mant[2:0]) || w_ovf))
                                || (r_s1_kind == K_UFLOW);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_flags <= '0;
        end else if (w_s2_adv && r_s1_valid) begin
            out_flags <= w_flags;
        end
    end
`endif

endmodule

`default_nettype wire
